// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage controller and its watchdog.
// Holds the FSM state encoding, MEM/WB record layout and the misaligned/conflicting access check.
package mem_stage_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_W       = 5;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // How the MEM/WB register is updated on the next clock edge
  typedef enum logic [2:0] {
    WB_HOLD   = 3'd0,
    WB_PASS   = 3'd1,
    WB_NOWR   = 3'd2,
    WB_BUBBLE = 3'd3,
    WB_LOAD   = 3'd4
  } wb_sel_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rd;
    logic              memtoreg;
    logic              regwrite;
  } wb_t;

  // Word accesses must be aligned, and a single op cannot both read and write
  function automatic logic access_fault(input logic [1:0] addr_lsb,
                                        input logic       rd,
                                        input logic       wr);
    return (addr_lsb != 2'b00) || (rd && wr);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for outstanding memory accesses: counts cycles while count=1, cleared by clear.
// expired is combinational from the count; the counter saturates once expired.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // The count holds k-1 during the k-th access cycle, so expiry lands on cycle TIMEOUT
  assign expired = (cnt == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: issues data-memory requests, builds MEM/WB; 1-cycle latency for ALU ops, memory ops wait for ack.
// Backpressure: stall holds upstream while an access is pending; a watchdog aborts unanswered accesses.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] Add,
  input  logic              Zero,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [REG_W-1:0]  Mux,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchTarget,
  output logic [DATA_W-1:0] ReadData_Out,
  output logic [DATA_W-1:0] ALUResult_Out,
  output logic [REG_W-1:0]  Mux_Out,
  output logic              MemtoReg_Out,
  output logic              RegWrite_Out,
  output logic              err
);

  state_t  state, state_nxt;
  wb_sel_t wb_sel;
  wb_t     wb_q, wb_nxt, wb_pass;
  logic    memop, fault, expired;
  logic    issue, retire, err_set;

  assign memop = MemRead | MemWrite;
  assign fault = access_fault(ALUResult[1:0], MemRead, MemWrite);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ACCESS),
    .count   (state == ACCESS),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wb_sel    = WB_HOLD;
    stall     = 1'b0;
    issue     = 1'b0;
    retire    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          if (!memop) begin
            wb_sel = WB_PASS;
          end else if (fault) begin
            wb_sel  = WB_NOWR;
            err_set = 1'b1;
          end else begin
            stall     = 1'b1;
            issue     = 1'b1;
            wb_sel    = WB_BUBBLE;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack arriving on the expiry cycle still completes the access normally
        if (mem_ack) begin
          wb_sel    = WB_LOAD;
          retire    = 1'b1;
          state_nxt = IDLE;
        end else if (expired) begin
          wb_sel    = WB_NOWR;
          retire    = 1'b1;
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    PCSrc = Branch & Zero & enable & ~stall;
  end

  assign BranchTarget = Add;

  assign wb_pass = '{rdata: '0, alu: ALUResult, rd: Mux, memtoreg: MemtoReg, regwrite: RegWrite};

  always_comb begin
    wb_nxt = wb_q;
    case (wb_sel)
      WB_PASS:   wb_nxt = wb_pass;
      WB_NOWR: begin
        wb_nxt          = wb_pass;
        wb_nxt.regwrite = 1'b0;
      end
      WB_BUBBLE: wb_nxt = '0;
      WB_LOAD: begin
        wb_nxt       = wb_pass;
        wb_nxt.rdata = mem_we ? '0 : mem_rdata;
      end
      default:   wb_nxt = wb_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q <= '0;
      err  <= 1'b0;
    end else begin
      wb_q <= wb_nxt;
      err  <= err_set;
    end
  end

  // Request fields are captured once at issue and stay put until ack or abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWrite;
      mem_addr  <= ALUResult;
      mem_wdata <= ReadData2;
    end else if (retire) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  assign ReadData_Out  = wb_q.rdata;
  assign ALUResult_Out = wb_q.alu;
  assign Mux_Out       = wb_q.rd;
  assign MemtoReg_Out  = wb_q.memtoreg;
  assign RegWrite_Out  = wb_q.regwrite;

endmodule
